l2_mem_bridge: RTL

- Sits directly downstream of the L2 cache's memory port (mem_req_*/mem_rsp_*) at the core top level.
- Converts each single wide cache-line request (read fill or dirty writeback) into a sequence of narrow beats on a simple valid/ready external memory bus.
- Reassembles read beats into a full line and returns one response pulse to the L2.
- One line transaction in flight at a time.
- Beats within a transaction are pipelined; responses return in order.

---
 rtl/l2_mem_bridge.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/l2_mem_bridge.sv
// rtl/l2_mem_bridge.sv - splits L2 line requests into narrow external beats and reassembles read lines
// Optional response watchdog enabled by defining L2_MEM_BRIDGE_TIMEOUT_EN.
module l2_mem_bridge #(
  parameter int ADDR_W          = 64,
  parameter int LINE_BITS       = 128,
  parameter int BEAT_BITS       = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int TIMEOUT_CYC     = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_req_valid,
  input  logic [ADDR_W-1:0]    mem_req_addr,
  input  logic [LINE_BITS-1:0] mem_req_store_data,
  input  logic [3:0]           mem_req_opcode,
  output logic                 mem_rsp_valid,
  output logic [LINE_BITS-1:0] mem_rsp_load_data,
  output logic                 ext_req_valid,
  input  logic                 ext_req_ready,
  output logic [ADDR_W-1:0]    ext_req_addr,
  output logic                 ext_req_we,
  output logic [BEAT_BITS-1:0] ext_req_wdata,
  input  logic                 ext_rsp_valid,
  input  logic [BEAT_BITS-1:0] ext_rsp_rdata,
  output logic                 busy,
  output logic                 bus_error
);
  localparam int NBEATS   = LINE_BITS / BEAT_BITS;
  localparam int LINE_LSB = $clog2(LINE_BITS / 8);
  localparam int BEAT_SH  = $clog2(BEAT_BITS / 8);
  localparam int CW       = $clog2(NBEATS) + 1;
  localparam logic [CW-1:0] NB_C   = CW'(NBEATS);
  localparam logic [CW-1:0] MAXO_C = CW'(MAX_OUTSTANDING);
  localparam logic [3:0] OP_RD = 4'd4;
  localparam logic [3:0] OP_WR = 4'd7;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_RESP = 2'd2, S_DONE = 2'd3} state_t;

  state_t                r_state, w_next_state;
  logic [ADDR_W-1:0]     r_base;
  logic                  r_is_read;
  logic [LINE_BITS-1:0]  r_wline, r_buf, r_rsp_data, w_buf_next;
  logic [CW-1:0]         r_issue_cnt, r_rsp_cnt, w_outstanding;
  logic                  r_bus_error;
  logic                  w_accept, w_op_ok, w_req_valid, w_req_fire;
  logic                  w_rsp_take, w_rsp_bad, w_last_rsp, w_abort;
  logic [BEAT_BITS-1:0]  w_wdata;
  logic                  w_unused;

  assign w_op_ok       = (mem_req_opcode == OP_RD) || (mem_req_opcode == OP_WR);
  assign w_accept      = (r_state == S_IDLE) && mem_req_valid;
  assign w_outstanding = r_issue_cnt - r_rsp_cnt;
  assign w_req_valid   = (r_state == S_ISSUE) && (r_issue_cnt < NB_C) && (w_outstanding < MAXO_C);
  assign w_req_fire    = w_req_valid && ext_req_ready;
  // Responses only count while a beat is actually awaited; anything else is a protocol error.
  assign w_rsp_take    = ext_rsp_valid && (r_state == S_ISSUE) && (w_outstanding != '0);
  assign w_rsp_bad     = ext_rsp_valid && !w_rsp_take;
  assign w_last_rsp    = w_rsp_take && (r_rsp_cnt == NB_C - 1'b1);
  assign w_unused      = &{1'b0, mem_req_addr[LINE_LSB-1:0], (TIMEOUT_CYC > 0)};

`ifdef L2_MEM_BRIDGE_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);
  logic [WDW-1:0] r_wd;
  logic           w_wd_run;

  assign w_wd_run = (r_state == S_ISSUE) && (w_outstanding != '0) && !ext_rsp_valid;
  assign w_abort  = w_wd_run && (r_wd == WDW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset || !w_wd_run) r_wd <= '0;
    else                    r_wd <= r_wd + 1'b1;
  end
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (mem_req_valid) w_next_state = w_op_ok ? S_ISSUE : S_RESP;
      S_ISSUE: if (w_last_rsp || w_abort) w_next_state = S_RESP;
      S_RESP:  w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_wdata = '0;
    for (int i = 0; i < NBEATS; i++)
      if (r_issue_cnt == CW'(i)) w_wdata = r_wline[i*BEAT_BITS +: BEAT_BITS];
    mem_rsp_valid     = (r_state == S_RESP);
    mem_rsp_load_data = r_rsp_data;
    busy              = (r_state != S_IDLE);
    bus_error         = r_bus_error;
    ext_req_valid     = w_req_valid;
    ext_req_addr      = w_req_valid ? r_base + (ADDR_W'(r_issue_cnt) << BEAT_SH) : '0;
    ext_req_we        = w_req_valid && !r_is_read;
    ext_req_wdata     = (w_req_valid && !r_is_read) ? w_wdata : '0;
  end

  always_comb begin
    w_buf_next = r_buf;
    for (int i = 0; i < NBEATS; i++)
      if (w_rsp_take && (r_rsp_cnt == CW'(i))) w_buf_next[i*BEAT_BITS +: BEAT_BITS] = ext_rsp_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_base      <= '0;
      r_is_read   <= 1'b0;
      r_wline     <= '0;
      r_buf       <= '0;
      r_rsp_data  <= '0;
      r_issue_cnt <= '0;
      r_rsp_cnt   <= '0;
      r_bus_error <= 1'b0;
    end else begin
      r_buf <= w_buf_next;
      if (w_accept) begin
        r_base      <= {mem_req_addr[ADDR_W-1:LINE_LSB], {LINE_LSB{1'b0}}};
        r_is_read   <= (mem_req_opcode == OP_RD);
        r_wline     <= mem_req_store_data;
        r_issue_cnt <= '0;
        r_rsp_cnt   <= '0;
      end else begin
        if (w_req_fire) r_issue_cnt <= r_issue_cnt + 1'b1;
        if (w_rsp_take) r_rsp_cnt   <= r_rsp_cnt + 1'b1;
      end
      // The final beat lands in the same cycle as the RESP transition, so capture the merged buffer.
      if (w_accept && !w_op_ok)
        r_rsp_data <= '0;
      else if ((r_state == S_ISSUE) && (w_next_state == S_RESP))
        r_rsp_data <= (r_is_read && !w_abort) ? w_buf_next : '0;
      if ((w_accept && !w_op_ok) || w_abort || w_rsp_bad)
        r_bus_error <= 1'b1;
    end
  end
endmodule
